// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns M-stage load/store requests into a req/ack bus
// handshake, stalling the pipeline until the access completes or times out.
// Optional macro DMEM_ALIGN_CHECK_EN rejects word-misaligned accesses without touching the bus.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    stateT       state;
    stateT       nextState;
    logic [7:0]  waitCnt;
    logic [7:0]  nextWaitCnt;
    logic [31:0] addrLatch;
    logic [31:0] wdataLatch;
    logic        weLatch;
    logic        access;
    logic        latchEn;
    logic        ackDone;
    logic        timeoutHit;
    logic        errSet;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    assign access = memreadM | memwriteM;
`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (aluoutM[1:0] != 2'b00);
`endif

    // Next-state, wait-counter and completion-event decode.
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        latchEn     = 1'b0;
        ackDone     = 1'b0;
        timeoutHit  = 1'b0;
        errSet      = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
`ifdef DMEM_ALIGN_CHECK_EN
                    if (misaligned) begin
                        nextState = DONE;
                        errSet    = 1'b1;
                    end else begin
                        nextState   = BUSY;
                        latchEn     = 1'b1;
                        nextWaitCnt = 8'd0;
                    end
`else
                    nextState   = BUSY;
                    latchEn     = 1'b1;
                    nextWaitCnt = 8'd0;
`endif
                end else begin
                    nextState = IDLE;
                end
            end
            BUSY: begin
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    nextState = DONE;
                    ackDone   = 1'b1;
                end else if (waitCnt == WAIT_LAST) begin
                    nextState  = DONE;
                    timeoutHit = 1'b1;
                    errSet     = 1'b1;
                end else begin
                    nextWaitCnt = waitCnt + 8'd1;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State, latched request, load data and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            waitCnt    <= 8'd0;
            addrLatch  <= 32'd0;
            wdataLatch <= 32'd0;
            weLatch    <= 1'b0;
            readdataM  <= 32'd0;
            bus_err    <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
            if (latchEn) begin
                addrLatch  <= aluoutM;
                wdataLatch <= writedataM;
                weLatch    <= memwriteM;
            end
            // Only loads update the load-data register; stores leave it alone.
            if (ackDone && !weLatch) begin
                readdataM <= mem_rdata;
            end else if (timeoutHit && !weLatch) begin
                readdataM <= TIMEOUT_DATA;
            end
            if (errSet) begin
                bus_err <= 1'b1;
            end
        end
    end

    // The stall must rise in the same cycle the request appears, hence combinational.
    assign stallM    = ((state == IDLE) && access) || (state == BUSY);
    assign mem_req   = (state == BUSY);
    assign mem_we    = (state == BUSY) && weLatch;
    assign mem_addr  = addrLatch;
    assign mem_wdata = wdataLatch;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (TIMEOUT=4): load, store, back-to-back,
// read+write priority, reset mid-access, timeout and misaligned access.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        memreadM;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; memreadM = 1'b0; memwriteM = 1'b0; aluoutM = 32'd0;
        writedataM = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        #2;
        check("rst_readdata", readdataM, 32'd0);
        check("rst_buserr", bus_err, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_stall", stallM, 1'b0);
        check("rst_addr", mem_addr, 32'd0);
        tick(); rst = 1'b0;
        tick();

        // Load 0x10, ack in first BUSY cycle
        memreadM = 1'b1; aluoutM = 32'h10; #1;
        check("ld_idle_stall", stallM, 1'b1);
        check("ld_idle_req", mem_req, 1'b0);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h12345678; #1;
        check("ld_busy_stall", stallM, 1'b1);
        check("ld_busy_req", mem_req, 1'b1);
        check("ld_busy_we", mem_we, 1'b0);
        check("ld_busy_addr", mem_addr, 32'h10);
        tick(); mem_ack = 1'b0; mem_rdata = 32'd0; #1;
        check("ld_done_stall", stallM, 1'b0);
        check("ld_done_req", mem_req, 1'b0);
        check("ld_done_data", readdataM, 32'h12345678);
        tick(); memreadM = 1'b0; #1;
        check("ld_idle2_stall", stallM, 1'b0);
        check("ld_idle2_data", readdataM, 32'h12345678);

        // Ack outside BUSY is ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF; #1;
        check("stray_ack_req", mem_req, 1'b0);
        tick(); mem_ack = 1'b0; #1;
        check("stray_ack_data", readdataM, 32'h12345678);

        // Store 0x20 / A5A5A5A5, ack in third BUSY cycle
        memwriteM = 1'b1; aluoutM = 32'h20; writedataM = 32'hA5A5A5A5; #1;
        check("st_idle_stall", stallM, 1'b1);
        tick(); #1;
        check("st_b1_req", mem_req, 1'b1);
        check("st_b1_we", mem_we, 1'b1);
        check("st_b1_addr", mem_addr, 32'h20);
        check("st_b1_wdata", mem_wdata, 32'hA5A5A5A5);
        tick(); aluoutM = 32'hFFFFFFFF; writedataM = 32'h0; #1;
        check("st_b2_stall", stallM, 1'b1);
        check("st_b2_addr", mem_addr, 32'h20);
        check("st_b2_wdata", mem_wdata, 32'hA5A5A5A5);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h99999999; #1;
        check("st_b3_req", mem_req, 1'b1);
        check("st_b3_stall", stallM, 1'b1);
        check("st_b3_addr", mem_addr, 32'h20);
        tick(); mem_ack = 1'b0; #1;
        check("st_done_stall", stallM, 1'b0);
        check("st_done_req", mem_req, 1'b0);
        check("st_done_data", readdataM, 32'h12345678);
        tick(); memwriteM = 1'b0; #1;

        // Back-to-back load 0x40 then store 0x44
        memreadM = 1'b1; aluoutM = 32'h40; #1;
        tick(); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
        check("b2b_ld_req", mem_req, 1'b1);
        check("b2b_ld_addr", mem_addr, 32'h40);
        tick(); mem_ack = 1'b0; #1;
        check("b2b_ld_done_req", mem_req, 1'b0);
        check("b2b_ld_data", readdataM, 32'hCAFEF00D);
        tick(); memreadM = 1'b0; memwriteM = 1'b1; aluoutM = 32'h44; writedataM = 32'h11112222; #1;
        check("b2b_idle_req", mem_req, 1'b0);
        check("b2b_idle_stall", stallM, 1'b1);
        tick(); mem_ack = 1'b1; #1;
        check("b2b_st_req", mem_req, 1'b1);
        check("b2b_st_we", mem_we, 1'b1);
        check("b2b_st_addr", mem_addr, 32'h44);
        tick(); mem_ack = 1'b0; #1;
        check("b2b_st_done_req", mem_req, 1'b0);
        tick(); memwriteM = 1'b0; #1;
        check("b2b_no_reissue", mem_req, 1'b0);
        check("b2b_data", readdataM, 32'hCAFEF00D);

        // Read and write together behave as a store
        memreadM = 1'b1; memwriteM = 1'b1; aluoutM = 32'h50; writedataM = 32'h5A5A0000; #1;
        tick(); mem_ack = 1'b1; mem_rdata = 32'h0BADF00D; #1;
        check("rw_we", mem_we, 1'b1);
        tick(); mem_ack = 1'b0; #1;
        check("rw_data", readdataM, 32'hCAFEF00D);
        tick(); memreadM = 1'b0; memwriteM = 1'b0; #1;

        // Reset in the second BUSY cycle, then a late ack
        memreadM = 1'b1; aluoutM = 32'h60; #1;
        tick(); #1;
        check("rstb_b1_req", mem_req, 1'b1);
        tick(); rst = 1'b1; memreadM = 1'b0; #1;
        check("rstb_req", mem_req, 1'b0);
        check("rstb_stall", stallM, 1'b0);
        check("rstb_we", mem_we, 1'b0);
        check("rstb_addr", mem_addr, 32'd0);
        check("rstb_data", readdataM, 32'd0);
        tick(); rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777; #1;
        check("late_ack_req", mem_req, 1'b0);
        tick(); mem_ack = 1'b0; #1;
        check("late_ack_data", readdataM, 32'd0);
        check("late_ack_stall", stallM, 1'b0);

        // Timeout: no ack for TIMEOUT=4 BUSY cycles
        memreadM = 1'b1; aluoutM = 32'h70; #1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check($sformatf("to_busy%0d_req", i), mem_req, 1'b1);
            check($sformatf("to_busy%0d_stall", i), stallM, 1'b1);
        end
        tick(); #1;
        check("to_done_req", mem_req, 1'b0);
        check("to_done_stall", stallM, 1'b0);
        check("to_done_data", readdataM, 32'hDEADBEEF);
        check("to_done_err", bus_err, 1'b1);
        tick(); memreadM = 1'b0; #1;
        tick(); tick(); #1;
        check("to_err_sticky", bus_err, 1'b1);
        rst = 1'b1; #1;
        check("to_err_rst", bus_err, 1'b0);
        tick(); rst = 1'b0; #1;

        // Misaligned load at 0x13
        memreadM = 1'b1; aluoutM = 32'h13; #1;
        check("mis_idle_stall", stallM, 1'b1);
        check("mis_idle_req", mem_req, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        tick(); #1;
        check("mis_done_req", mem_req, 1'b0);
        check("mis_done_stall", stallM, 1'b0);
        check("mis_done_err", bus_err, 1'b1);
        check("mis_done_data", readdataM, 32'd0);
        tick(); memreadM = 1'b0; #1;
        check("mis_idle2_req", mem_req, 1'b0);
`else
        tick(); mem_ack = 1'b1; mem_rdata = 32'h13131313; #1;
        check("mis_busy_req", mem_req, 1'b1);
        check("mis_busy_addr", mem_addr, 32'h13);
        tick(); mem_ack = 1'b0; #1;
        check("mis_done_data", readdataM, 32'h13131313);
        check("mis_done_err", bus_err, 1'b0);
        tick(); memreadM = 1'b0; #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, range 2-255: max BUSY cycles waited for mem_ack.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port memreadM, input, 1, M-stage load request.
REQ-005 SHALL have port memwriteM, input, 1, M-stage store request.
REQ-006 SHALL have port aluoutM, input, 32, byte address of the access.
REQ-007 SHALL have port writedataM, input, 32, store data.
REQ-008 SHALL have port readdataM, output, 32, load data to the M/W register.
REQ-009 SHALL have port stallM, output, 1, freezes F/D/E/M and bubbles W while high.
REQ-010 SHALL have port mem_req, output, 1, bus request.
REQ-011 SHALL have port mem_we, output, 1, bus write enable.
REQ-012 SHALL have port mem_addr, output, 32, bus address.
REQ-013 SHALL have port mem_wdata, output, 32, bus write data.
REQ-014 SHALL have port mem_ack, input, 1, bus completion, single-cycle pulse.
REQ-015 SHALL have port mem_rdata, input, 32, bus read data, valid with mem_ack.
REQ-016 SHALL have port bus_err, output, 1, sticky error flag.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-018 IDLE: access = memreadM|memwriteM; if access, latch aluoutM, writedataM, we=memwriteM into registers and go BUSY; else stay IDLE.
REQ-019 memreadM and memwriteM both high SHALL be treated as a store (we=1).
REQ-020 stallM SHALL be combinational: high when (state==IDLE & access) or state==BUSY; low in DONE and idle.
REQ-021 BUSY: mem_req=1 with mem_we/mem_addr/mem_wdata driven from the latched registers, stable every BUSY cycle.
REQ-022 mem_req SHALL be 0 in IDLE and DONE; mem_ack outside BUSY SHALL be ignored.
REQ-023 BUSY with mem_ack=1: load captures mem_rdata into readdataM register; go DONE.
REQ-024 BUSY wait counter SHALL clear on entry and increment each BUSY cycle without ack; reaching TIMEOUT SHALL go DONE, load readdataM=32'hDEADBEEF, set bus_err.
REQ-025 DONE SHALL last exactly one cycle, then IDLE; the pipeline advances on that edge so the same access is never reissued.
REQ-026 Minimum latency: ack in first BUSY cycle gives 2 stall cycles; data on readdataM during DONE.
REQ-027 readdataM SHALL hold its last value except on load completion; stores never change it.
REQ-028 bus_err SHALL stay set until reset.

Reset
REQ-029 rst SHALL force, asynchronously: state IDLE, counter 0, readdataM 0, bus_err 0, latched addr/data/we 0.
REQ-030 rst mid-BUSY SHALL drop mem_req immediately; an ack arriving after rst deasserts with state IDLE is ignored.

Configuration
REQ-031 Macro DMEM_ALIGN_CHECK_EN SHALL compile in alignment checking.
REQ-032 With DMEM_ALIGN_CHECK_EN: access with aluoutM[1:0]!=0 goes IDLE->DONE directly, no bus request, readdataM unchanged, bus_err set; stallM high in that IDLE cycle only.
REQ-033 Without DMEM_ALIGN_CHECK_EN: address passed unmodified; no alignment logic present.

Verification
REQ-034 Load addr 0x00000010, mem_ack with mem_rdata 0x12345678 in first BUSY cycle -> stallM high 2 cycles, readdataM=0x12345678 in DONE, mem_req high 1 cycle.
REQ-035 Store addr 0x20, data 0xA5A5A5A5, ack after 3 cycles -> mem_we=1, mem_addr/mem_wdata stable 3 BUSY cycles, readdataM unchanged, stallM high 4 cycles.
REQ-036 Load, no ack, TIMEOUT=4 -> 4 BUSY cycles, readdataM=0xDEADBEEF, bus_err=1 held until rst.
REQ-037 rst pulse in 2nd BUSY cycle -> mem_req=0 immediately, all outputs reset values; late ack ignored.
REQ-038 Back-to-back load then store -> two separate BUSY phases separated by DONE+IDLE, each issued once.
REQ-039 With DMEM_ALIGN_CHECK_EN, load addr 0x13 -> no mem_req, 1 stall cycle, bus_err=1; without macro, mem_addr=0x13 issued.
